baccarat_fsm: RTL and testbench

BACCARAT_FSM -- requirements
Module: baccarat_fsm

---
 rtl/baccarat_pkg.sv | 19 +
 rtl/banker_rule.sv | 25 ++
 rtl/baccarat_fsm.sv | 100 ++++++++++
 tb/tb_baccarat_fsm.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// Shared state encoding and card/score constants for the baccarat round controller.
package baccarat_pkg;

    typedef enum logic [3:0] {
        DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL,
        DEAL_P3, BANK_EVAL, DEAL_D3, RESULT, DONE
    } state_t;

    localparam logic [3:0] NATURAL_MIN      = 4'd8;
    localparam logic [3:0] FACE_MIN         = 4'd10;
    localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;
    localparam logic [3:0] TALLY_MAX        = 4'd15;

    // Tens and faces count zero; rank 0 (no card) also maps to zero.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank >= FACE_MIN) ? 4'd0 : rank;
    endfunction

endpackage

// File: rtl/banker_rule.sv
// Banker third-card draw table, keyed on banker total and player third-card value.
module banker_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    logic [3:0] v;
    assign v = card_value(pcard3);

    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_fsm.sv
// Round sequencer: deals cards via load strobes, applies drawing rules, keeps win lights and tallies.
module baccarat_fsm
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       step,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       new_hand,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic [3:0] player_wins,
    output logic [3:0] dealer_wins,
    output logic [3:0] ties,
    output logic       round_done
);

    state_t state, state_nxt;
    logic   banker_draw;
    logic   go;

    banker_rule u_banker_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (banker_draw)
    );

    assign go = step && !reset;

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state            <= DEAL_P1;
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
            player_wins      <= 4'd0;
            dealer_wins      <= 4'd0;
            ties             <= 4'd0;
        end else if (step) begin
            state <= state_nxt;
            if (state == RESULT) begin
                player_win_light <= (pscore >= dscore);
                dealer_win_light <= (dscore >= pscore);
                if (pscore > dscore) begin
                    if (player_wins != TALLY_MAX) player_wins <= player_wins + 4'd1;
                end else if (dscore > pscore) begin
                    if (dealer_wins != TALLY_MAX) dealer_wins <= dealer_wins + 4'd1;
                end else begin
                    if (ties != TALLY_MAX) ties <= ties + 4'd1;
                end
            end else if (state == DONE) begin
                player_win_light <= 1'b0;
                dealer_win_light <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        load_pcard1 = 1'b0;
        load_pcard2 = 1'b0;
        load_pcard3 = 1'b0;
        load_dcard1 = 1'b0;
        load_dcard2 = 1'b0;
        load_dcard3 = 1'b0;
        new_hand    = reset;
        round_done  = (state == DONE) && !reset;
        case (state)
            DEAL_P1: begin state_nxt = DEAL_D1; load_pcard1 = go; end
            DEAL_D1: begin state_nxt = DEAL_P2; load_dcard1 = go; end
            DEAL_P2: begin state_nxt = DEAL_D2; load_pcard2 = go; end
            DEAL_D2: begin state_nxt = EVAL;    load_dcard2 = go; end
            EVAL: begin
                if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN)
                    state_nxt = RESULT;
                else if (pscore < PLAYER_STAND_MIN)
                    state_nxt = DEAL_P3;
                // Player stood on 6/7: banker draws on 0..5 without the table.
                else if (dscore <= 4'd5)
                    state_nxt = DEAL_D3;
                else
                    state_nxt = RESULT;
            end
            DEAL_P3:   begin state_nxt = BANK_EVAL; load_pcard3 = go; end
            BANK_EVAL: state_nxt = banker_draw ? DEAL_D3 : RESULT;
            DEAL_D3:   begin state_nxt = RESULT; load_dcard3 = go; end
            RESULT:    state_nxt = DONE;
            DONE:      begin state_nxt = DEAL_P1; new_hand = reset || go; end
            default:   state_nxt = DEAL_P1;
        endcase
    end

endmodule

// File: tb/tb_baccarat_fsm.sv
// Self-checking bench: directed and random hands against a rule-level baccarat model.
module tb_baccarat_fsm;

    logic       slow_clock, reset, step;
    logic [3:0] pscore, dscore, pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       new_hand, player_win_light, dealer_win_light, round_done;
    logic [3:0] player_wins, dealer_wins, ties;

    int tests = 0;
    int fails = 0;
    int m_pw = 0, m_dw = 0, m_ti = 0;

    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_NEW  = 7'b1000000;
    localparam logic [6:0] S_P1   = 7'b0100000;
    localparam logic [6:0] S_D1   = 7'b0010000;
    localparam logic [6:0] S_P2   = 7'b0001000;
    localparam logic [6:0] S_D2   = 7'b0000100;
    localparam logic [6:0] S_P3   = 7'b0000010;
    localparam logic [6:0] S_D3   = 7'b0000001;

    logic [6:0] strobes;
    assign strobes = {new_hand, load_pcard1, load_dcard1, load_pcard2,
                      load_dcard2, load_pcard3, load_dcard3};

    baccarat_fsm dut (
        .slow_clock       (slow_clock),
        .reset            (reset),
        .step             (step),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .new_hand         (new_hand),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .player_wins      (player_wins),
        .dealer_wins      (dealer_wins),
        .ties             (ties),
        .round_done       (round_done)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rnd();
        return 4'($urandom_range(0, 15));
    endfunction

    // Punto banco banker rule written from the printed casino table.
    function automatic bit bank_draws(input int d, input int rank);
        int v;
        v = (rank >= 10) ? 0 : rank;
        if (d <= 2) return 1;
        if (d == 3) return v != 8;
        if (d == 4) return v inside {[2:7]};
        if (d == 5) return v inside {[4:7]};
        if (d == 6) return v inside {[6:7]};
        return 0;
    endfunction

    task automatic step_once(input string tag, input logic [6:0] exp_strb,
                             input logic [3:0] p, input logic [3:0] d, input logic [3:0] c3);
        @(negedge slow_clock);
        pscore = p; dscore = d; pcard3 = c3; step = 1'b1;
        #1 chk(tag, 16'(strobes), 16'(exp_strb));
        @(posedge slow_clock);
        #1 step = 1'b0;
    endtask

    task automatic chk_tallies(input string tag);
        chk(tag, {4'd0, player_wins, dealer_wins, ties},
            {4'd0, 4'(m_pw), 4'(m_dw), 4'(m_ti)});
    endtask

    task automatic play_hand(input int p, input int d, input int c3,
                             input int fp, input int fd, input int hold);
        bit natural, pdraw, bdraw;
        natural = (p >= 8) || (d >= 8);
        pdraw   = !natural && (p <= 5);
        bdraw   = natural ? 0 : (pdraw ? bank_draws(d, c3) : (d <= 5));
        step_once("deal_p1", S_P1, rnd(), rnd(), rnd());
        step_once("deal_d1", S_D1, rnd(), rnd(), rnd());
        step_once("deal_p2", S_P2, rnd(), rnd(), rnd());
        step_once("deal_d2", S_D2, rnd(), rnd(), rnd());
        for (int i = 0; i < hold; i++) begin
            @(negedge slow_clock);
            pscore = rnd(); dscore = rnd();
            #1 chk("hold_strobes", 16'(strobes), 16'(S_NONE));
            chk("hold_lights", {14'd0, player_win_light, dealer_win_light}, 16'd0);
            chk("hold_done", 16'(round_done), 16'd0);
        end
        step_once("eval", S_NONE, 4'(p), 4'(d), rnd());
        if (pdraw) begin
            step_once("deal_p3", S_P3, rnd(), rnd(), rnd());
            step_once("bank_eval", S_NONE, rnd(), 4'(d), 4'(c3));
        end
        if (bdraw) step_once("deal_d3", S_D3, rnd(), rnd(), rnd());
        step_once("result", S_NONE, 4'(fp), 4'(fd), rnd());
        if (fp > fd)      m_pw = (m_pw < 15) ? m_pw + 1 : 15;
        else if (fd > fp) m_dw = (m_dw < 15) ? m_dw + 1 : 15;
        else              m_ti = (m_ti < 15) ? m_ti + 1 : 15;
        chk("lights", {14'd0, player_win_light, dealer_win_light},
            {14'd0, 1'(fp >= fd), 1'(fd >= fp)});
        chk_tallies("tallies");
        chk("round_done", 16'(round_done), 16'd1);
        step_once("done_new_hand", S_NEW, rnd(), rnd(), rnd());
        chk("lights_clear", {14'd0, player_win_light, dealer_win_light}, 16'd0);
        chk("round_done_clear", 16'(round_done), 16'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge slow_clock);
        reset = 1'b1; step = 1'b1;
        #1 chk({tag, "_strobes"}, 16'(strobes), 16'(S_NEW));
        chk({tag, "_round_done"}, 16'(round_done), 16'd0);
        @(posedge slow_clock);
        #1 reset = 1'b0; step = 1'b0;
        m_pw = 0; m_dw = 0; m_ti = 0;
        chk_tallies({tag, "_tallies"});
        chk({tag, "_lights"}, {14'd0, player_win_light, dealer_win_light}, 16'd0);
    endtask

    initial begin
        int p, d, c3, fp, fd;
        bit nat;
        reset = 1'b0; step = 1'b0; pscore = '0; dscore = '0; pcard3 = '0;
        do_reset("init");

        play_hand(8, 3, 0, 8, 3, 0);        // natural, player wins
        play_hand(4, 6, 7, 1, 9, 0);        // both draw, dealer wins
        play_hand(2, 3, 13, 5, 4, 0);       // face card: banker on 3 draws
        play_hand(2, 3, 8, 4, 5, 0);        // banker on 3 stands against an 8
        play_hand(6, 6, 0, 6, 6, 0);        // both stand, tie
        play_hand(7, 4, 0, 7, 5, 5);        // idle in EVAL, then banker draws

        for (int n = 0; n < 40; n++) begin
            p  = $urandom_range(0, 9);
            d  = $urandom_range(0, 9);
            c3 = $urandom_range(1, 13);
            nat = (p >= 8) || (d >= 8);
            fp = nat ? p : $urandom_range(0, 9);
            fd = nat ? d : $urandom_range(0, 9);
            play_hand(p, d, c3, fp, fd, 0);
        end

        step_once("mid_p1", S_P1, rnd(), rnd(), rnd());
        step_once("mid_d1", S_D1, rnd(), rnd(), rnd());
        step_once("mid_p2", S_P2, rnd(), rnd(), rnd());
        do_reset("mid_reset");

        for (int n = 0; n < 17; n++) play_hand(9, 0, 0, 9, 0, 0);
        chk("saturate", 16'(player_wins), 16'd15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
